keypoint_stream_reader: RTL and testbench

- Downstream consumer of the two keypoint SRAMs filled by the detect/filter stage (scale pair 1 and scale pair 2).
- After detection finishes, reads all keypoint_1 entries, then all keypoint_2 entries, and emits them as one valid/ready stream tagged with scale.
- The stream feeds the orientation/descriptor stage.
- Hides the 1-cycle SRAM read latency behind a 2-entry skid FIFO, so throughput is 1 keypoint/cycle under no backpressure.

---
 rtl/sift_kp_pkg.sv | 22 ++
 rtl/kp_skid_fifo.sv | 41 ++++
 rtl/keypoint_stream_reader.sv | 142 ++++++++++++++
 tb/tb_keypoint_stream_reader.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sift_kp_pkg.sv
// Shared definitions for the keypoint reader path.
// Holds the default keypoint field widths, the bit positions of the row and
// col fields inside a stored keypoint word, the default image geometry and
// the reader FSM state encoding.
package sift_kp_pkg;
  localparam int KP_ROW_W     = 9;
  localparam int KP_COL_W     = 10;
  // stored word: [ROW_LSB +: ROW_W] = row, [COL_LSB +: COL_W] = col
  localparam int KP_COL_LSB   = 0;
  localparam int KP_ROW_LSB   = KP_COL_W;
  // stream word adds the scale tag above the stored word
  localparam int KP_SCALE_BIT = KP_ROW_W + KP_COL_W;
  localparam int KP_IMG_ROWS  = 480;
  localparam int KP_IMG_COLS  = 640;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD1   = 2'd1,
    S_RD2   = 2'd2,
    S_DRAIN = 2'd3
  } rd_state_e;
endpackage

// File: rtl/kp_skid_fifo.sv
// Two-entry register FIFO that absorbs the SRAM read latency.
// Ports: clk, rst_n (async low), push/din write side, pop read side,
// count (0..2) and head (oldest entry; zero after reset).
// A push and a pop in the same cycle are legal when full: the head slot is
// read combinationally before it is overwritten at the edge.
module kp_skid_fifo #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [1:0][W-1:0] mem;
  logic              wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/keypoint_stream_reader.sv
// Reads keypoint SRAM 1 then keypoint SRAM 2 after detection and emits every
// entry as one valid/ready stream {scale, row, col}, scale 0 for SRAM 1.
// Ports: clk, rst_n (async low); start pulse / done pulse; kp1_count and
// kp2_count entry counts; keypoint_N_re/addr/dout SRAM read ports (1-cycle
// latency); kp_valid/kp_ready/kp_data stream; kp_emitted beats this run.
// Build option: define KP_BORDER_REJECT_EN to drop entries lying within
// BORDER pixels of the image edge at FIFO push (they still use a read slot).
module keypoint_stream_reader
  import sift_kp_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int ROW_W    = KP_ROW_W,
  parameter int COL_W    = KP_COL_W,
  parameter int BORDER   = 4,
  parameter int IMG_ROWS = KP_IMG_ROWS,
  parameter int IMG_COLS = KP_IMG_COLS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   done,
  input  logic [ADDR_W:0]        kp1_count,
  input  logic [ADDR_W:0]        kp2_count,
  output logic                   keypoint_1_re,
  output logic [ADDR_W-1:0]      keypoint_1_addr,
  input  logic [ROW_W+COL_W-1:0] keypoint_1_dout,
  output logic                   keypoint_2_re,
  output logic [ADDR_W-1:0]      keypoint_2_addr,
  input  logic [ROW_W+COL_W-1:0] keypoint_2_dout,
  output logic                   kp_valid,
  input  logic                   kp_ready,
  output logic [ROW_W+COL_W:0]   kp_data,
  output logic [ADDR_W+1:0]      kp_emitted
);
  localparam int KP_W = ROW_W + COL_W;
`ifdef KP_BORDER_REJECT_EN
  localparam bit REJECT_EN = 1'b1;
`else
  localparam bit REJECT_EN = 1'b0;
`endif
  localparam logic [ROW_W-1:0] ROW_LO = ROW_W'(BORDER);
  localparam logic [ROW_W-1:0] ROW_HI = ROW_W'(IMG_ROWS - BORDER);
  localparam logic [COL_W-1:0] COL_LO = COL_W'(BORDER);
  localparam logic [COL_W-1:0] COL_HI = COL_W'(IMG_COLS - BORDER);

  rd_state_e         state, state_nxt;
  logic [ADDR_W:0]   cnt1_q, cnt2_q, cur_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic              issue, inflight, infl_scale, last_rd, credit, drained;
  logic              pop, push, keep;
  logic [1:0]        fifo_count;
  logic [KP_W-1:0]   rd_data;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;

  assign kp_valid = (fifo_count != 2'd0);
  assign pop      = kp_valid & kp_ready;

  // Slots already claimed (stored + one in flight) minus the slot freed this
  // cycle must leave room for the read about to be issued.
  assign credit  = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign cur_cnt = (state == S_RD2) ? cnt2_q : cnt1_q;
  assign last_rd = ({1'b0, rd_addr} == (cur_cnt - 1'b1));

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    drained   = 1'b0;
    case (state)
      S_IDLE:
        if (start) begin
          if (kp1_count != '0)      state_nxt = S_RD1;
          else if (kp2_count != '0) state_nxt = S_RD2;
          else                      state_nxt = S_DRAIN;
        end
      S_RD1, S_RD2:
        if (credit) begin
          issue = 1'b1;
          if (last_rd)
            state_nxt = (state == S_RD1 && cnt2_q != '0) ? S_RD2 : S_DRAIN;
        end
      S_DRAIN:
        // done is registered, so fire on the cycle the last beat leaves
        if (!inflight && (fifo_count - {1'b0, pop}) == 2'd0) begin
          drained   = 1'b1;
          state_nxt = S_IDLE;
        end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      rd_addr    <= '0;
      inflight   <= 1'b0;
      infl_scale <= 1'b0;
      kp_emitted <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      done       <= drained;
      inflight   <= issue;
      infl_scale <= (state == S_RD2);
      if (state == S_IDLE && start) begin
        cnt1_q     <= kp1_count;
        cnt2_q     <= kp2_count;
        rd_addr    <= '0;
        kp_emitted <= '0;
      end else begin
        // restart at 0 for the second SRAM; also stops a wrap past 2047
        if (issue) rd_addr <= last_rd ? '0 : rd_addr + 1'b1;
        if (pop)   kp_emitted <= kp_emitted + 1'b1;
      end
    end
  end

  assign keypoint_1_re   = issue && (state == S_RD1);
  assign keypoint_2_re   = issue && (state == S_RD2);
  assign keypoint_1_addr = rd_addr;
  assign keypoint_2_addr = rd_addr;

  assign rd_data = infl_scale ? keypoint_2_dout : keypoint_1_dout;
  assign rd_row  = rd_data[COL_W +: ROW_W];
  assign rd_col  = rd_data[0 +: COL_W];
  assign keep    = !REJECT_EN ||
                   (rd_row >= ROW_LO && rd_row < ROW_HI &&
                    rd_col >= COL_LO && rd_col < COL_HI);
  assign push    = inflight && keep;

  kp_skid_fifo #(.W(KP_W + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({infl_scale, rd_data}),
    .pop   (pop),
    .count (fifo_count),
    .head  (kp_data)
  );
endmodule

// File: tb/tb_keypoint_stream_reader.sv
// Directed bench for keypoint_stream_reader with behavioural 1-cycle SRAMs.
module tb_keypoint_stream_reader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, kp_ready = 1'b0;
  logic [11:0] kp1_count = '0, kp2_count = '0;
  logic        keypoint_1_re, keypoint_2_re, kp_valid, done;
  logic [10:0] keypoint_1_addr, keypoint_2_addr;
  logic [18:0] keypoint_1_dout = '0, keypoint_2_dout = '0;
  logic [19:0] kp_data;
  logic [12:0] kp_emitted;

  logic [18:0] mem1 [2048];
  logic [18:0] mem2 [2048];

  int n_cmp = 0, n_err = 0;

  `define CHK(tag, obs, exp) begin n_cmp++; assert ((obs) === (exp)) else begin n_err++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (keypoint_1_re) keypoint_1_dout <= mem1[keypoint_1_addr];
    if (keypoint_2_re) keypoint_2_dout <= mem2[keypoint_2_addr];
  end

  keypoint_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .kp1_count(kp1_count), .kp2_count(kp2_count),
    .keypoint_1_re(keypoint_1_re), .keypoint_1_addr(keypoint_1_addr), .keypoint_1_dout(keypoint_1_dout),
    .keypoint_2_re(keypoint_2_re), .keypoint_2_addr(keypoint_2_addr), .keypoint_2_dout(keypoint_2_dout),
    .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_data(kp_data), .kp_emitted(kp_emitted)
  );

  int first_re, first_valid, done_cyc, done_n, re1_n, re2_n, last1, max_out;
  int seq_err, stab_err, valid_n, pops, berr;
  logic [19:0] bq[$];
  int          bc[$];

  function automatic logic [19:0] exp_beat(int i, int c1);
    return (i < c1) ? {1'b0, mem1[i]} : {1'b1, mem2[i-c1]};
  endfunction

  // rmode 0: ready held high; rmode 1: ready 1,0,0,1 repeating plus a stray
  // start pulse mid-run that must be ignored.
  task automatic run(input int c1, input int c2, input int rmode, input int budget);
    logic        prev_stall;
    logic [19:0] prev_data;
    first_re = -1; first_valid = -1; done_cyc = -1; done_n = 0; re1_n = 0; re2_n = 0;
    last1 = -1; max_out = 0; seq_err = 0; stab_err = 0; valid_n = 0; pops = 0;
    bq.delete(); bc.delete();
    prev_stall = 1'b0; prev_data = '0;
    @(negedge clk);
    start = 1'b1; kp1_count = 12'(c1); kp2_count = 12'(c2);
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (rmode == 0) kp_ready = 1'b1;
      else kp_ready = (((cyc-1) % 4) == 0) || (((cyc-1) % 4) == 3);
      if (rmode == 1 && cyc == 4) begin start = 1'b1; kp1_count = 12'd1; end
      if (rmode == 1 && cyc == 5) begin start = 1'b0; kp1_count = 12'(c1); end
      @(negedge clk);
      if (keypoint_1_re) begin
        if (int'(keypoint_1_addr) != re1_n || re1_n >= c1) seq_err++;
        last1 = int'(keypoint_1_addr); re1_n++;
      end
      if (keypoint_2_re) begin
        if (keypoint_1_re || re1_n != c1 || int'(keypoint_2_addr) != re2_n || re2_n >= c2) seq_err++;
        re2_n++;
      end
      if ((keypoint_1_re || keypoint_2_re) && first_re < 0) first_re = cyc;
      if (kp_valid) begin
        valid_n++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (prev_stall && (!kp_valid || kp_data !== prev_data)) stab_err++;
      prev_stall = kp_valid && !kp_ready;
      prev_data  = kp_data;
      if (kp_valid && kp_ready) begin bq.push_back(kp_data); bc.push_back(cyc); pops++; end
      if (re1_n + re2_n - pops > max_out) max_out = re1_n + re2_n - pops;
      if (done) begin done_n++; done_cyc = cyc; end
      if (done_n > 0 && cyc >= done_cyc + 3) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic count_beat_errs(input int c1);
    berr = 0;
    foreach (bq[i]) if (bq[i] !== exp_beat(i, c1)) berr++;
  endtask

  initial begin
    mem1[0] = {9'd10, 10'd20}; mem1[1] = {9'd11, 10'd21}; mem1[2] = {9'd12, 10'd22};
    mem2[0] = {9'd30, 10'd40}; mem2[1] = {9'd31, 10'd41};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    `CHK("reset_outs", {keypoint_1_re, keypoint_2_re, kp_valid, done, kp_data, kp_emitted, keypoint_1_addr, keypoint_2_addr}, 58'd0)
    @(negedge clk); rst_n = 1'b1;

    // 3+2, ready high
    run(3, 2, 0, 40);
    `CHK("t1_first_re", first_re, 1)
    `CHK("t1_first_valid", first_valid, 3)
    `CHK("t1_nbeats", bq.size(), 5)
    for (int i = 0; i < 5 && i < bq.size(); i++) begin
      `CHK("t1_beat_data", bq[i], exp_beat(i, 3))
      `CHK("t1_beat_cyc", bc[i], 3 + i)
    end
    `CHK("t1_seq", seq_err, 0)
    `CHK("t1_done_cyc", done_cyc, 8)
    `CHK("t1_done_n", done_n, 1)
    `CHK("t1_emitted", kp_emitted, 13'd5)
    `CHK("t1_data_beat3_scale1", (bq.size() > 3) ? bq[3] : 20'hx, {1'b1, 9'd30, 10'd40})

    // 3+2, ready toggling, stray start ignored
    run(3, 2, 1, 80);
    `CHK("t2_nbeats", bq.size(), 5)
    count_beat_errs(3);
    `CHK("t2_beat_errs", berr, 0)
    `CHK("t2_stable", stab_err, 0)
    `CHK("t2_ahead_le2", (max_out <= 2), 1'b1)
    `CHK("t2_seq", seq_err, 0)
    `CHK("t2_done_after_last", done_cyc, (bc.size() == 5) ? bc[4] + 1 : -2)
    `CHK("t2_done_n", done_n, 1)
    `CHK("t2_emitted", kp_emitted, 13'd5)

    // both counts zero
    run(0, 0, 0, 20);
    `CHK("t3_no_re", re1_n + re2_n, 0)
    `CHK("t3_no_valid", valid_n, 0)
    `CHK("t3_done_cyc", done_cyc, 2)
    `CHK("t3_done_n", done_n, 1)
    `CHK("t3_emitted", kp_emitted, 13'd0)

    // async reset at cycle 5 of a 3+2 run
    @(negedge clk);
    start = 1'b1; kp1_count = 12'd3; kp2_count = 12'd2; kp_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    `CHK("t4_rst_outs", {keypoint_1_re, keypoint_2_re, kp_valid, done, kp_data, kp_emitted}, 36'd0)
    done_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || kp_valid) done_n++;
    end
    `CHK("t4_quiet_in_reset", done_n, 0)
    rst_n = 1'b1;
    run(3, 2, 0, 40);
    `CHK("t4_nbeats", bq.size(), 5)
    count_beat_errs(3);
    `CHK("t4_beat_errs", berr, 0)
    `CHK("t4_first_valid", first_valid, 3)
    `CHK("t4_done_cyc", done_cyc, 8)
    `CHK("t4_emitted", kp_emitted, 13'd5)

    // border entries
    mem1[0] = {9'd2, 10'd100}; mem1[1] = {9'd100, 10'd100}; mem1[2] = {9'd100, 10'd638};
    run(3, 0, 0, 40);
`ifdef KP_BORDER_REJECT_EN
    `CHK("t5_nbeats", bq.size(), 1)
    `CHK("t5_beat", (bq.size() > 0) ? bq[0] : 20'hx, {1'b0, 9'd100, 10'd100})
    `CHK("t5_emitted", kp_emitted, 13'd1)
`else
    `CHK("t5_nbeats", bq.size(), 3)
    count_beat_errs(3);
    `CHK("t5_beat_errs", berr, 0)
    `CHK("t5_emitted", kp_emitted, 13'd3)
`endif
    `CHK("t5_done_cyc", done_cyc, 6)

    // full 2048-entry SRAM 1
    for (int i = 0; i < 2048; i++) mem1[i] = 19'(i * 37 + 5);
    run(2048, 0, 0, 2200);
    `CHK("t6_nbeats", bq.size(), 2048)
    count_beat_errs(2048);
    `CHK("t6_beat_errs", berr, 0)
    `CHK("t6_last_addr", last1, 2047)
    `CHK("t6_nreads", re1_n, 2048)
    `CHK("t6_seq", seq_err, 0)
    `CHK("t6_done_cyc", done_cyc, 2051)
    `CHK("t6_emitted", kp_emitted, 13'd2048)

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
